// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder split into NGROUPS = WIDTH/BLOCK
// carry-lookahead groups, one register stage per group, with the group carry
// passed stage to stage. Valid/ready handshake with a global stall.
// Optional feature macro: PCLA_OVF_EN adds the signed-overflow output ovf.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef PCLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NGROUPS = (BLOCK < 1) ? 1 : WIDTH / BLOCK;

  if (BLOCK < 1) begin : g_bad_block
    $error("pipelined_cla_adder: BLOCK must be at least 1");
  end else if (WIDTH % BLOCK != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK");
  end

  // Carries c[0..BLOCK] of one group. Every c[i+1] is a flat sum of products
  // of g/p terms and c0, so no carry depends on a previously computed carry.
  // c[BLOCK] is the group generate OR group propagate AND c0.
  function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] ga,
                                               input logic [BLOCK-1:0] gb,
                                               input logic             c0);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             gen;
    logic             prop;
    logic             term;
    g    = ga & gb;
    p    = ga ^ gb;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLOCK; i++) begin
      gen  = 1'b0;
      prop = 1'b1;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        gen  = gen | term;
        prop = prop & p[j];
      end
      c[i+1] = gen | (prop & c0);
    end
    return c;
  endfunction

  // Global stall: everything moves together unless a result is waiting
  logic adv;
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_stage
    localparam int IW = WIDTH - k * BLOCK;  // operand bits not yet added
    localparam int SW = (k + 1) * BLOCK;    // sum bits resolved after stage k

    logic [IW-1:0]    a_in;
    logic [IW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [BLOCK:0]   cv;
    logic [BLOCK-1:0] grp_s;
    logic [SW-1:0]    s_nxt;
    logic             vld_p;
    logic             c_p;
    logic [SW-1:0]    s_p;

    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = b;
      assign c_in  = cin;
      assign v_in  = in_valid;
      assign s_nxt = grp_s;
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_dly.a_p;
      assign b_in  = g_stage[k-1].g_dly.b_p;
      assign c_in  = g_stage[k-1].c_p;
      assign v_in  = g_stage[k-1].vld_p;
      assign s_nxt = {grp_s, g_stage[k-1].s_p};
    end

    assign cv    = lookahead(a_in[BLOCK-1:0], b_in[BLOCK-1:0], c_in);
    assign grp_s = a_in[BLOCK-1:0] ^ b_in[BLOCK-1:0] ^ cv[BLOCK-1:0];

    // ---- stage k boundary: valid bit shifts on every advance (bubbles move)
    always_ff @(posedge clk) begin
      if (rst)      vld_p <= 1'b0;
      else if (adv) vld_p <= v_in;
    end

    // Result bits and group carry, captured only for real operations
    always_ff @(posedge clk) begin
      if (rst) begin
        s_p <= '0;
        c_p <= 1'b0;
      end else if (adv && v_in) begin
        s_p <= s_nxt;
        c_p <= cv[BLOCK];
      end
    end

    if (k < NGROUPS - 1) begin : g_dly
      logic [IW-BLOCK-1:0] a_p;
      logic [IW-BLOCK-1:0] b_p;
      // Operand bits for the groups still ahead travel beside the stage
      always_ff @(posedge clk) begin
        if (rst) begin
          a_p <= '0;
          b_p <= '0;
        end else if (adv && v_in) begin
          a_p <= a_in[IW-1:BLOCK];
          b_p <= b_in[IW-1:BLOCK];
        end
      end
    end

`ifdef PCLA_OVF_EN
    if (k == NGROUPS - 1) begin : g_ovf
      logic ovf_p;
      // Signed overflow: carry into the MSB differs from carry out of it
      always_ff @(posedge clk) begin
        if (rst)               ovf_p <= 1'b0;
        else if (adv && v_in)  ovf_p <= cv[BLOCK] ^ cv[BLOCK-1];
      end
    end
`endif
  end

  assign out_valid = g_stage[NGROUPS-1].vld_p;
  assign sum       = g_stage[NGROUPS-1].s_p;
  assign carry     = g_stage[NGROUPS-1].c_p;
`ifdef PCLA_OVF_EN
  assign ovf       = g_stage[NGROUPS-1].g_ovf.ovf_p;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=16, BLOCK=4): directed cases plus
// randomized traffic with random backpressure against a queue-based model.
module tb_pipelined_cla_adder;
  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int NG    = WIDTH / BLOCK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef PCLA_OVF_EN
  logic             ovf;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } res_t;

  res_t             exp_q[$];
  int               n_chk  = 0;
  int               n_pass = 0;
  logic             stall_seen = 1'b0;
  logic [WIDTH-1:0] held_s = '0;
  logic             held_c = 1'b0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry    (carry)
`ifdef PCLA_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer addition, signed range test for overflow
  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci);
    res_t            r;
    longint unsigned tot;
    int              sx;
    int              sy;
    int              st;
    tot = longint'(x) + longint'(y) + longint'(ci);
    r.s = tot[WIDTH-1:0];
    r.c = tot[WIDTH];
    sx  = $signed(x);
    sy  = $signed(y);
    st  = sx + sy + int'(ci);
    r.o = (st > (2**(WIDTH-1) - 1)) || (st < -(2**(WIDTH-1)));
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(5))
      0:       return '0;
      1:       return '1;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return r[WIDTH-1:0];
    endcase
  endfunction

  // Scoreboard and hold monitor, sampled mid-cycle where handshake is stable
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_seen <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {31'b0, out_valid}, 32'h0);
        end else begin
          check("sb_sum", {16'b0, sum}, {16'b0, exp_q[0].s});
          check("sb_carry", {31'b0, carry}, {31'b0, exp_q[0].c});
`ifdef PCLA_OVF_EN
          check("sb_ovf", {31'b0, ovf}, {31'b0, exp_q[0].o});
`endif
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
      if (out_valid && !out_ready) begin
        if (stall_seen) begin
          check("hold_sum", {16'b0, sum}, {16'b0, held_s});
          check("hold_carry", {31'b0, carry}, {31'b0, held_c});
        end
        held_s     <= sum;
        held_c     <= carry;
        stall_seen <= 1'b1;
      end else begin
        stall_seen <= 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands and hold them until accepted (bounded)
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    int   g;
    logic acc;
    g        = 0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = ci;
    do begin
      #1;
      acc = in_ready;
      step();
      g++;
    end while (!acc && g < 50);
    if (!acc) check("send_timeout", 32'h0, 32'h1);
  endtask

  // Cycles from the accept edge until out_valid (bounded)
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic drain();
    int g;
    g         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && g < 200) begin
      step();
      g++;
    end
    check("drain_empty", exp_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int               lat;
    logic             acc;
    logic [WIDTH-1:0] b2b_s[3];
    logic             b2b_c[3];

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_sum", {16'b0, sum}, 32'h0);
    check("rst_carry", {31'b0, carry}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
`ifdef PCLA_OVF_EN
    check("rst_ovf", {31'b0, ovf}, 32'h0);
`endif

    // Full wrap-around with carry out
    send(16'hFFFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("wrap_latency", lat, NG);
    check("wrap_sum", {16'b0, sum}, 32'h0000);
    check("wrap_carry", {31'b0, carry}, 32'h1);
    step();

    send(16'h1234, 16'h4321, 1'b1);
    in_valid = 1'b0;
    wait_out(lat);
    check("cin_sum", {16'b0, sum}, 32'h5556);
    check("cin_carry", {31'b0, carry}, 32'h0);
    step();

    // Carry crossing all group boundaries
    send(16'h0F0F, 16'h00F1, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("xgrp_sum", {16'b0, sum}, 32'h1000);
    check("xgrp_carry", {31'b0, carry}, 32'h0);
    step();

    // Back-to-back accepts give back-to-back results
    b2b_s[0] = 16'h0002; b2b_c[0] = 1'b0;
    b2b_s[1] = 16'h0000; b2b_c[1] = 1'b1;
    b2b_s[2] = 16'hFFFE; b2b_c[2] = 1'b1;
    send(16'h0001, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    for (int i = 0; i < 3; i++) begin
      check("b2b_valid", {31'b0, out_valid}, 32'h1);
      check("b2b_sum", {16'b0, sum}, {16'b0, b2b_s[i]});
      check("b2b_carry", {31'b0, carry}, {31'b0, b2b_c[i]});
      step();
    end
    check("b2b_done", {31'b0, out_valid}, 32'h0);

    // Backpressure: fill pipe, stall 3 cycles with a new op waiting
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(pick(), pick(), 1'($urandom_range(1)));
    in_valid = 1'b1;
    a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", {31'b0, in_ready}, 32'h0);
      check("bp_valid", {31'b0, out_valid}, 32'h1);
      check("bp_front_sum", {16'b0, sum}, {16'b0, exp_q[0].s});
      check("bp_queued", exp_q.size(), 32'd4);
      step();
    end
    out_ready = 1'b1;
    send(16'hA5A5, 16'h5A5A, 1'b1);
    drain();

    // Reset mid-flight discards everything in the pipe
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h3333, 16'h4444, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("flush_valid", {31'b0, out_valid}, 32'h0);
      step();
    end
    send(16'h00FF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("post_rst_latency", lat, NG);
    check("post_rst_sum", {16'b0, sum}, 32'h0100);
    step();

`ifdef PCLA_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("ovf_pos_sum", {16'b0, sum}, 32'h8000);
    check("ovf_pos_ovf", {31'b0, ovf}, 32'h1);
    check("ovf_pos_carry", {31'b0, carry}, 32'h0);
    step();
    send(16'hFFFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("ovf_neg_ovf", {31'b0, ovf}, 32'h0);
    check("ovf_neg_carry", {31'b0, carry}, 32'h1);
    step();
`endif

    // Randomized traffic with random backpressure
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        a        = pick();
        b        = pick();
        cin      = 1'($urandom_range(1));
      end
      out_ready = ($urandom_range(9) < 7);
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
